// File: rtl/or_gate_sweep_checker.sv
// Purpose: self-checking sweep harness for an enabled reduction-OR gate.
//          Sources {en,a} exhaustively, checks b against ~en & |a, and reports
//          the error count, the first failing vector and pass/fail.
// Latency: SETTLE+2 cycles per vector; done pulses one cycle after the last CHECK.
// Backpressure: none; start is accepted only in IDLE, and abort forces FINISH.
module or_gate_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERRW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a_out,
    output logic             en_out,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH:0]   fail_vec,
    output logic             fail_seen
);

    // The last index has every bit set: the en=1, a=all-ones vector.
    localparam logic [WIDTH:0] LAST_IDX  = '1;
    // The WAIT counter is preloaded so that WAIT lasts exactly SETTLE cycles.
    localparam logic [3:0]     WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH:0]  idx;
    logic [3:0]      wait_cnt;
    logic            expected;
    logic            mismatch;
    logic            do_check;
    logic            last_vec;
    logic [ERRW-1:0] err_sat;

    // The applied vector is the sweep index itself. It therefore stays stable
    // through WAIT and CHECK and keeps its last value after the sweep ends.
    assign a_out  = idx[WIDTH-1:0];
    assign en_out = idx[WIDTH];

    // Golden model and compare. The case-inequality makes an X or Z on b_in
    // count as a mismatch in simulation.
    always_comb begin
        expected = ~en_out & (|a_out);
        mismatch = (b_in !== expected);
        do_check = (state == S_CHECK) && !abort;
        last_vec = (idx == LAST_IDX);
        err_sat  = (&err_count) ? err_count : err_count + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status decode. Abort takes priority over every busy state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_FINISH;
                end else if (SETTLE == 0) begin
                    state_nxt = S_CHECK;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_FINISH;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (abort || last_vec) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_APPLY;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep index and settle timer. The terminal compare happens before the
    // increment, so the index never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            wait_cnt <= 4'd0;
        end else begin
            if (state == S_IDLE && start) begin
                idx <= '0;
            end else if (do_check && !last_vec) begin
                idx <= idx + 1'b1;
            end

            if (state == S_APPLY) begin
                wait_cnt <= WAIT_LAST;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Result bookkeeping. Values are cleared on an accepted start. pass is set
    // only when the final vector is checked, so an aborted sweep reports fail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            fail_vec  <= '0;
            fail_seen <= 1'b0;
            pass      <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err_count <= '0;
            fail_vec  <= '0;
            fail_seen <= 1'b0;
            pass      <= 1'b0;
        end else if (do_check) begin
            if (mismatch) begin
                err_count <= err_sat;
                if (!fail_seen) begin
                    fail_vec  <= {en_out, a_out};
                    fail_seen <= 1'b1;
                end
            end
            if (last_vec) begin
                pass <= !mismatch && (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_or_gate_sweep_checker.sv
// Bench for or_gate_sweep_checker: three instances (defaults, ERRW=4, SETTLE=0),
// each driving a behavioural gate with a selectable fault mode. Expected sweep
// results are queued at start and compared when done pulses.
module tb_or_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Instance 0: defaults
    logic st0, ab0, en0, b0, bz0, dn0, ps0, fs0;
    logic [3:0] a0;
    logic [7:0] er0;
    logic [4:0] fv0;
    int md0;
    // Instance 1: ERRW=4
    logic st1, ab1, en1, b1, bz1, dn1, ps1, fs1;
    logic [3:0] a1;
    logic [3:0] er1;
    logic [4:0] fv1;
    int md1;
    // Instance 2: SETTLE=0
    logic st2, ab2, en2, b2, bz2, dn2, ps2, fs2;
    logic [3:0] a2;
    logic [7:0] er2;
    logic [4:0] fv2;
    int md2;

    typedef struct {
        int       err;
        logic [4:0] fv;
        logic     fs;
        logic     ps;
    } res_t;
    res_t exp_q[$];

    // Gate models: 0 correct, 1 stuck-1, 2 ignores en, 3 stuck-0, 4 inverted
    function automatic logic gate(input int mode, input logic [3:0] a, input logic en);
        case (mode)
            0:       return ~en & (|a);
            1:       return 1'b1;
            2:       return |a;
            3:       return 1'b0;
            default: return ~(~en & (|a));
        endcase
    endfunction

    assign b0 = gate(md0, a0, en0);
    assign b1 = gate(md1, a1, en1);
    assign b2 = gate(md2, a2, en2);

    or_gate_sweep_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .abort(ab0), .a_out(a0), .en_out(en0),
        .b_in(b0), .busy(bz0), .done(dn0), .pass(ps0), .err_count(er0),
        .fail_vec(fv0), .fail_seen(fs0)
    );

    or_gate_sweep_checker #(.WIDTH(4), .SETTLE(1), .ERRW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .abort(ab1), .a_out(a1), .en_out(en1),
        .b_in(b1), .busy(bz1), .done(dn1), .pass(ps1), .err_count(er1),
        .fail_vec(fv1), .fail_seen(fs1)
    );

    or_gate_sweep_checker #(.WIDTH(4), .SETTLE(0), .ERRW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .abort(ab2), .a_out(a2), .en_out(en2),
        .b_in(b2), .busy(bz2), .done(dn2), .pass(ps2), .err_count(er2),
        .fail_vec(fv2), .fail_seen(fs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       st0 = v;
            1:       st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic set_abort(input int w, input logic v);
        case (w)
            0:       ab0 = v;
            1:       ab1 = v;
            default: ab2 = v;
        endcase
    endtask

    function automatic logic get_done(input int w);
        return (w == 0) ? dn0 : (w == 1) ? dn1 : dn2;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? bz0 : (w == 1) ? bz1 : bz2;
    endfunction

    function automatic logic [4:0] get_vec(input int w);
        return (w == 0) ? {en0, a0} : (w == 1) ? {en1, a1} : {en2, a2};
    endfunction

    function automatic res_t get_res(input int w);
        res_t r;
        case (w)
            0:       begin r.err = int'(er0); r.fv = fv0; r.fs = fs0; r.ps = ps0; end
            1:       begin r.err = int'(er1); r.fv = fv1; r.fs = fs1; r.ps = ps1; end
            default: begin r.err = int'(er2); r.fv = fv2; r.fs = fs2; r.ps = ps2; end
        endcase
        return r;
    endfunction

    // Drive a one-cycle start (optionally with abort); returns in sweep cycle 1.
    task automatic pulse_start(input int w, input logic with_abort);
        set_start(w, 1'b1);
        if (with_abort) set_abort(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        set_abort(w, 1'b0);
    endtask

    // Called in sweep cycle 1. Checks the vector at each APPLY cycle, pulses
    // start in cycle mid_start (should be ignored), waits for done (bounded),
    // pops the scoreboard and compares, then checks done is a single pulse.
    task automatic run_to_done(input string tag, input int w, input int per,
                               input int mid_start, output int cyc);
        res_t r;
        res_t e;
        cyc = 1;
        while (!get_done(w) && cyc < 400) begin
            if ((cyc - 1) % per == 0) begin
                chk({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
                chk({tag, "_vec"}, 32'(get_vec(w)), 32'((cyc - 1) / per));
            end
            set_start(w, cyc == mid_start);
            @(posedge clk); #1;
            cyc++;
        end
        set_start(w, 1'b0);
        chk({tag, "_done_seen"}, 32'(get_done(w)), 32'd1);
        if (get_done(w)) begin
            r = get_res(w);
            e = exp_q.pop_front();
            chk({tag, "_err"},  32'(r.err), 32'(e.err));
            chk({tag, "_fvec"}, 32'(r.fv),  32'(e.fv));
            chk({tag, "_fseen"}, 32'(r.fs), 32'(e.fs));
            chk({tag, "_pass"}, 32'(r.ps),  32'(e.ps));
            chk({tag, "_busy_at_done"}, 32'(get_busy(w)), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
            chk({tag, "_fvec_hold"}, 32'(get_res(w).fv), 32'(e.fv));
        end
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n = 1'b0;
        st0 = 0; ab0 = 0; st1 = 0; ab1 = 0; st2 = 0; ab2 = 0;
        md0 = 0; md1 = 0; md2 = 0;
        #12;
        // Reset state
        chk("rst_a",    32'(a0),  32'd0);
        chk("rst_en",   32'(en0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_done", 32'(dn0), 32'd0);
        chk("rst_pass", 32'(ps0), 32'd0);
        chk("rst_err",  32'(er0), 32'd0);
        chk("rst_fvec", 32'(fv0), 32'd0);
        chk("rst_fseen", 32'(fs0), 32'd0);
        chk("rst_all1", 32'({a1, en1, bz1, dn1, ps1, er1, fv1, fs1}), 32'd0);
        chk("rst_all2", 32'({a2, en2, bz2, dn2, ps2, er2, fv2, fs2}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort in IDLE is ignored
        set_abort(0, 1'b1);
        @(posedge clk); #1;
        set_abort(0, 1'b0);
        chk("idle_abort_busy", 32'(bz0), 32'd0);
        chk("idle_abort_done", 32'(dn0), 32'd0);

        // 1: correct gate; a start mid-sweep is ignored
        md0 = 0;
        exp_q.push_back('{err: 0, fv: 5'h00, fs: 1'b0, ps: 1'b1});
        pulse_start(0, 1'b0);
        run_to_done("t1", 0, 3, 50, cyc);
        chk("t1_done_cycle", 32'(cyc), 32'd97);

        // 2: stuck-at-1; start and abort together in IDLE, start wins
        md0 = 1;
        exp_q.push_back('{err: 17, fv: 5'h00, fs: 1'b1, ps: 1'b0});
        pulse_start(0, 1'b1);
        run_to_done("t2", 0, 3, 0, cyc);
        chk("t2_done_cycle", 32'(cyc), 32'd97);

        // 3: gate ignores enable
        md0 = 2;
        exp_q.push_back('{err: 15, fv: 5'h11, fs: 1'b1, ps: 1'b0});
        pulse_start(0, 1'b0);
        run_to_done("t3", 0, 3, 0, cyc);

        // 4: ERRW=4, stuck-at-0 then inverted gate (32 mismatches saturate)
        md1 = 3;
        exp_q.push_back('{err: 15, fv: 5'h01, fs: 1'b1, ps: 1'b0});
        pulse_start(1, 1'b0);
        run_to_done("t4a", 1, 3, 0, cyc);
        md1 = 4;
        exp_q.push_back('{err: 15, fv: 5'h00, fs: 1'b1, ps: 1'b0});
        pulse_start(1, 1'b0);
        run_to_done("t4b", 1, 3, 0, cyc);

        // 5: abort after 10 checks, restart during FINISH ignored, next accepted
        md0 = 0;
        exp_q.push_back('{err: 0, fv: 5'h00, fs: 1'b0, ps: 1'b0});
        pulse_start(0, 1'b0);
        cyc = 1;
        while (cyc < 31) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_vec10", 32'({en0, a0}), 32'h0A);
        set_abort(0, 1'b1);
        @(posedge clk); #1;
        set_abort(0, 1'b0);
        set_start(0, 1'b1);
        begin
            res_t r;
            res_t e;
            r = get_res(0);
            e = exp_q.pop_front();
            chk("t5_done", 32'(dn0), 32'd1);
            chk("t5_busy", 32'(bz0), 32'd0);
            chk("t5_err",  32'(r.err), 32'(e.err));
            chk("t5_fseen", 32'(r.fs), 32'(e.fs));
            chk("t5_pass", 32'(r.ps), 32'(e.ps));
        end
        @(posedge clk); #1;
        chk("t5_finish_start_busy", 32'(bz0), 32'd0);
        chk("t5_finish_start_done", 32'(dn0), 32'd0);
        exp_q.push_back('{err: 0, fv: 5'h00, fs: 1'b0, ps: 1'b1});
        @(posedge clk); #1;
        set_start(0, 1'b0);
        run_to_done("t5r", 0, 3, 0, cyc);
        chk("t5r_done_cycle", 32'(cyc), 32'd97);

        // 6: reset mid-WAIT clears outputs immediately, no done; then SETTLE=0 run
        md0 = 1;
        pulse_start(0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t6_pre_fseen", 32'(fs0), 32'd1);
        chk("t6_pre_vec",   32'({en0, a0}), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({a0, en0, bz0, dn0, ps0, er0, fv0, fs0}), 32'd0);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (dn0 || bz0) seen++;
        end
        chk("t6_no_done", 32'(seen), 32'd0);
        md2 = 0;
        exp_q.push_back('{err: 0, fv: 5'h00, fs: 1'b0, ps: 1'b1});
        pulse_start(2, 1'b0);
        run_to_done("t6s0", 2, 2, 0, cyc);
        chk("t6s0_done_cycle", 32'(cyc), 32'd65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_gate_sweep_checker.md
Name: or_gate_sweep_checker

Overview:
- Clocked stimulus generator and response checker for the enabled reduction-OR gate block.
- Drives the gate's data and enable inputs through an exhaustive sweep and samples the gate output.
- Compares each sample against a golden model, then reports the error count, the first failing vector and pass/fail.
- Sits on the opposite side of the gate interface from the gate: it sources `a`/`en` and sinks `b`, replacing open-loop benches with a self-checking, synthesizable harness.

Parameters:
- WIDTH, 4: width of the gate data input `a`.
- SETTLE, 1: wait cycles between applying a vector and sampling `b_in`. Legal range 0..15.
- ERRW, 8: width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a sweep when idle.
- abort  input  1  stops an active sweep at the next edge.
- a_out  output  WIDTH  data vector driven to the gate's `a`.
- en_out  output  1  enable driven to the gate's `en`. Active-low: 0 = gate enabled.
- b_in  input  1  gate output `b`.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes or is aborted.
- pass  output  1  valid from `done` until the next start: 1 iff all vectors checked and err_count = 0.
- err_count  output  ERRW  mismatches in the current/last sweep; saturates at all-ones.
- fail_vec  output  WIDTH+1  {en,a} of the first mismatch; held until the next start.
- fail_seen  output  1  a mismatch has been recorded in this sweep.

Behaviour:

Golden model:
- expected = (~en_out) & (|a_out).
- en_out=1 forces expected 0.
- A mismatch is b_in != expected. An X or Z on b_in counts as a mismatch in simulation.

Reset (rst_n low, asynchronous):
- State = IDLE.
- a_out=0, en_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_seen=0.

FSM states: IDLE, APPLY, WAIT, CHECK, FINISH.
- IDLE: on start=1, clear err_count, fail_vec, fail_seen and pass; vector index = 0; go to APPLY. busy rises on the same edge.
- APPLY (1 cycle): a_out = idx[WIDTH-1:0], en_out = idx[WIDTH]. Go to WAIT, or to CHECK if SETTLE=0.
- WAIT: stay SETTLE cycles (counter), then go to CHECK.
- CHECK (1 cycle): sample b_in and compare.
  - On mismatch: err_count += 1 (saturating). If fail_seen=0, capture fail_vec = {en_out,a_out} and set fail_seen.
  - If idx = 2^(WIDTH+1)-1, go to FINISH. Otherwise idx+1 and go to APPLY.
- FINISH (1 cycle): done=1, busy=0, pass = (err_count==0). Return to IDLE.

Sweep order and latency:
- Sweep order: en=0 with a=0..2^WIDTH-1, then en=1 with a=0..2^WIDTH-1.
- a_out and en_out hold stable through WAIT and CHECK.
- Per-vector cost: SETTLE+2 cycles.
- With defaults: 32 vectors × 3 = 96 cycles from the first APPLY. done is asserted on cycle 97 after the start edge.
- a_out and en_out retain their last vector after the sweep.

Boundary conditions:
- start while busy: ignored.
- start coincident with done (FINISH): ignored. A new start is accepted from IDLE only.
- abort while busy: next edge goes to FINISH.
  - done pulses with pass=0, even if err_count=0.
  - err_count and fail_vec keep their values.
- abort in IDLE: ignored.
- abort and start in the same cycle in IDLE: start wins.
- Mismatch on the last vector: counted before FINISH.
- err_count saturation: holds at all-ones; no wrap.
- Index wrap: the index never wraps; the terminal compare precedes increment.
- rst_n low mid-sweep: immediate return to reset values. No done pulse is issued.

Test Plan:
1. Correct gate model (b = ~en & |a), defaults, start pulse → 32 checks; done at cycle 97; pass=1; err_count=0; fail_seen=0.
2. Gate output stuck at 1 → mismatches at {en,a}=5'h00 and all 16 en=1 vectors; err_count=17; fail_vec=5'h00; pass=0.
3. Gate ignoring en (b = |a) → 15 mismatches (en=1, a=1..F); fail_vec=5'h11; pass=0.
4. ERRW=4 with b stuck at 0 plus an inverted model (b = ~(~en&|a)) → 32 mismatches; err_count saturates at 4'hF.
5. Abort asserted after 10 checks → done next cycle; pass=0; busy=0. A second start is ignored during FINISH and accepted one cycle later.
6. rst_n pulsed low mid-WAIT → all outputs 0 asynchronously; no done. SETTLE=0 run afterward completes in 64 cycles with pass=1.
